// File: rtl/restoring_divider_seq_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// Holds the FSM state encoding and the iteration-counter width rule.
package restoring_divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DefaultWidth = 64;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits always suffice.
  function automatic int countWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/restoring_divider_seq_sub.sv
// N-bit ripple-carry subtractor: D = A + ~B + 1, cout = 1 means no borrow.
// Purely combinational; the divider uses cout as its commit/restore decision.
module rca_sub_nbit #(
  parameter int N = 65
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] D,
  output logic         cout
);

  logic [N:0]   carry;
  logic [N-1:0] bInv;

  assign bInv     = ~B;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : gBit
    assign D[i]         = A[i] ^ bInv[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & bInv[i]) | (carry[i] & (A[i] ^ bInv[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/restoring_divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor short-cut enabled by defining RDIV_DBZ_CHECK_EN.
module restoring_divider_seq
  import restoring_divider_seq_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH:0]   trialDiff;
  logic             trialCout;
  logic             commit;
  logic [WIDTH:0]   nextRem;
  logic [WIDTH-1:0] nextQuo;

  // The {R,Q} pair shifts left by one; R picks up the quotient MSB.
  assign shiftedRem = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  rca_sub_nbit #(
    .N(WIDTH + 1)
  ) uSub (
    .A   (shiftedRem),
    .B   ({1'b0, div_q}),
    .D   (trialDiff),
    .cout(trialCout)
  );

  // A set bit shifted out of R would also mean R already exceeds D.
  assign commit  = trialCout | rem_q[WIDTH];
  assign nextRem = commit ? trialDiff : shiftedRem;
  assign nextQuo = {quo_q[WIDTH-2:0], commit};

`ifdef RDIV_DBZ_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef RDIV_DBZ_CHECK_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          div_d   = divisor;
          quo_d   = dividend;
          rem_d   = '0;
          count_d = '0;
          state_d = RUN;
`ifdef RDIV_DBZ_CHECK_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d   = nextRem;
        quo_d   = nextQuo;
        count_d = count_q + CW'(1);
        if (count_q == LastCount) begin
          state_d     = DONE;
          quotient_d  = nextQuo;
          remainder_d = nextRem[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

`ifdef RDIV_DBZ_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed self-checking bench for restoring_divider_seq (WIDTH=16 and WIDTH=64).
// Expectations follow RDIV_DBZ_CHECK_EN when it is defined for the build.
module tb_restoring_divider_seq;

`ifdef RDIV_DBZ_CHECK_EN
  localparam bit DbzEn = 1'b1;
`else
  localparam bit DbzEn = 1'b0;
`endif
  localparam int ZeroLat = DbzEn ? 1 : 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  logic        start64;
  logic [63:0] dividend64, divisor64;
  logic        busy64, done64, dbz64;
  logic [63:0] quotient64, remainder64;

  int checks = 0;
  int errors = 0;
  logic overlapSeen = 1'b0;

  always #5 clk = ~clk;

  restoring_divider_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  restoring_divider_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .dividend(dividend64), .divisor(divisor64),
    .busy(busy64), .done(done64), .quotient(quotient64), .remainder(remainder64),
    .div_by_zero(dbz64)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy64 && done64)) overlapSeen = 1'b1;
  end

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called just after an edge; the following edge is the start edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // n counts cycles including the start edge; returns when done is seen or bound hits.
  task automatic waitDone(input int startN, output int n, output int busyN);
    n = startN;
    busyN = 0;
    while (!done && n < 100) begin
      if (busy) busyN++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic runOp(input vec_t v);
    int n, busyN;
    applyStimulus(v.a, v.b);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(1, n, busyN);
    checkOutput({v.name, " done"}, done, 1);
    checkOutput({v.name, " latency"}, n, v.lat);
    checkOutput({v.name, " busy cycles"}, busyN, v.lat - 1);
    checkOutput({v.name, " quotient"}, quotient, v.q);
    checkOutput({v.name, " remainder"}, remainder, v.r);
    checkOutput({v.name, " div_by_zero"}, div_by_zero, v.dbz);
    @(posedge clk); #1;
    checkOutput({v.name, " done pulse width"}, done, 0);
  endtask

  initial begin
    int n, busyN;
    logic doneSeen;

    vecs[0] = '{"65000/7",     16'd65000, 16'd7,     16'd9285,  16'd5,    1'b0,  17};
    vecs[1] = '{"50/10024",    16'd50,    16'd10024, 16'd0,     16'd50,   1'b0,  17};
    vecs[2] = '{"65535/1",     16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0,  17};
    vecs[3] = '{"1234/0",      16'd1234,  16'd0,     16'd65535, 16'd1234, DbzEn, ZeroLat};
    vecs[4] = '{"0/5",         16'd0,     16'd5,     16'd0,     16'd0,    1'b0,  17};
    vecs[5] = '{"65535/65535", 16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0,  17};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start64 = 1'b0; dividend64 = '0; divisor64 = '0;
    #2;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset div_by_zero", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) runOp(vecs[i]);

    // Back-to-back: start held high, second operands presented while the first runs.
    applyStimulus(16'd58135, 16'd3592);
    @(posedge clk); #1;
    dividend = 16'd1005;
    divisor  = 16'd69;
    waitDone(1, n, busyN);
    checkOutput("b2b first latency", n, 17);
    checkOutput("b2b first quotient", quotient, 16);
    checkOutput("b2b first remainder", remainder, 663);
    @(posedge clk); #1;
    checkOutput("b2b no idle busy", busy, 1);
    start = 1'b0;
    waitDone(1, n, busyN);
    checkOutput("b2b second latency", n, 17);
    checkOutput("b2b second quotient", quotient, 14);
    checkOutput("b2b second remainder", remainder, 39);
    @(posedge clk); #1;

    // Start pulse with new operands mid-run must be ignored.
    applyStimulus(16'd65000, 16'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(16'd3, 16'd3);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(6, n, busyN);
    checkOutput("ignored start latency", n, 17);
    checkOutput("ignored start quotient", quotient, 9285);
    checkOutput("ignored start remainder", remainder, 5);
    @(posedge clk); #1;

    // Reset at iteration 8 aborts with no done pulse.
    applyStimulus(16'd58135, 16'd3592);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort quotient", quotient, 0);
    checkOutput("abort remainder", remainder, 0);
    checkOutput("abort div_by_zero", div_by_zero, 0);
    #1;
    rst = 1'b0;
    doneSeen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) doneSeen = 1'b1;
    end
    checkOutput("abort no done pulse", doneSeen, 0);
    runOp('{"100/9", 16'd100, 16'd9, 16'd11, 16'd1, 1'b0, 17});

    // 64-bit instance.
    dividend64 = 64'hFFFF_FFFF_FFFF_FFFF;
    divisor64  = 64'h0000_0001_0000_0000;
    start64    = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    n = 1;
    while (!done64 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w64 done", done64, 1);
    checkOutput("w64 latency", n, 65);
    checkOutput("w64 quotient", quotient64, 64'h0000_0000_FFFF_FFFF);
    checkOutput("w64 remainder", remainder64, 64'h0000_0000_FFFF_FFFF);
    checkOutput("w64 div_by_zero", dbz64, 0);

    @(posedge clk); #1;
    checkOutput("busy/done overlap", overlapSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
